// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator.
//   phase_e    : position of a counter within one axis (active/front/sync/back)
//   VGA640_*   : 640x480@60 timing, negative sync polarity
//   VGA800_*   : 800x600@60 timing, positive sync polarity
//   calc_total : sum of the four phase lengths of one axis
package vga_pkg;

  typedef enum logic [1:0] {
    PH_ACT,
    PH_FP,
    PH_SYN,
    PH_BP
  } phase_e;

  localparam int unsigned VGA640_H_VISIBLE = 640;
  localparam int unsigned VGA640_H_FRONT   = 16;
  localparam int unsigned VGA640_H_SYNC    = 96;
  localparam int unsigned VGA640_H_BACK    = 48;
  localparam int unsigned VGA640_V_VISIBLE = 480;
  localparam int unsigned VGA640_V_FRONT   = 10;
  localparam int unsigned VGA640_V_SYNC    = 2;
  localparam int unsigned VGA640_V_BACK    = 33;
  localparam bit          VGA640_HSYNC_POL = 1'b0;
  localparam bit          VGA640_VSYNC_POL = 1'b0;

  localparam int unsigned VGA800_H_VISIBLE = 800;
  localparam int unsigned VGA800_H_FRONT   = 40;
  localparam int unsigned VGA800_H_SYNC    = 128;
  localparam int unsigned VGA800_H_BACK    = 88;
  localparam int unsigned VGA800_V_VISIBLE = 600;
  localparam int unsigned VGA800_V_FRONT   = 1;
  localparam int unsigned VGA800_V_SYNC    = 4;
  localparam int unsigned VGA800_V_BACK    = 23;
  localparam bit          VGA800_HSYNC_POL = 1'b1;
  localparam bit          VGA800_VSYNC_POL = 1'b1;

  function automatic int unsigned calc_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its phase FSM.
//   clk, rst     : clock, asynchronous active-high reset
//   i_step       : advance the axis by one position this edge
//   o_count      : current (registered) position 0..TOTAL-1
//   o_count_nxt  : position after this edge
//   o_phase_nxt  : phase after this edge
//   o_wrap       : this edge steps from TOTAL-1 back to 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_nxt,
  output phase_e           o_phase_nxt,
  output logic             o_wrap
);

  localparam int unsigned      TOTAL = calc_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] B_FP  = WIDTH'(VISIBLE);
  localparam logic [WIDTH-1:0] B_SYN = WIDTH'(VISIBLE + FRONT);
  localparam logic [WIDTH-1:0] B_BP  = WIDTH'(VISIBLE + FRONT + SYNC);

  logic [WIDTH-1:0] r_count;
  phase_e           r_phase;
  logic [WIDTH-1:0] w_count_nxt;
  phase_e           w_phase_nxt;
  logic             w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_phase <= PH_ACT;
    end else begin
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // The count moves by one per step, so each boundary is crossed exactly
  // when the next count equals it; phase lengths >= 1 keep them distinct.
  always_comb begin
    w_wrap      = i_step && (r_count == LAST);
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    if (i_step) begin
      w_count_nxt = w_wrap ? '0 : r_count + WIDTH'(1);
      unique case (r_phase)
        PH_ACT: if (w_count_nxt == B_FP)  w_phase_nxt = PH_FP;
        PH_FP:  if (w_count_nxt == B_SYN) w_phase_nxt = PH_SYN;
        PH_SYN: if (w_count_nxt == B_BP)  w_phase_nxt = PH_BP;
        PH_BP:  if (w_wrap)               w_phase_nxt = PH_ACT;
        default:                          w_phase_nxt = PH_ACT;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;
  assign o_phase_nxt = w_phase_nxt;
  assign o_wrap      = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator.
//   clk, rst    : pixel clock, asynchronous active-high reset
//   en          : pixel enable; the raster advances only when set
//   out_hsync   : horizontal sync (active level HSYNC_POL)
//   out_vsync   : vertical sync (active level VSYNC_POL)
//   out_hdata   : horizontal position 0..H_TOTAL-1
//   out_vdata   : vertical position 0..V_TOTAL-1
//   out_blank   : set outside the visible area
//   line_start  : one-cycle strobe when the position wraps to h=0
//   frame_start : one-cycle strobe when the position wraps to (0,0)
// All outputs are registered and describe the same raster position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned H_VISIBLE = VGA640_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA640_H_FRONT,
  parameter int unsigned H_SYNC    = VGA640_H_SYNC,
  parameter int unsigned H_BACK    = VGA640_H_BACK,
  parameter int unsigned V_VISIBLE = VGA640_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA640_V_FRONT,
  parameter int unsigned V_SYNC    = VGA640_V_SYNC,
  parameter int unsigned V_BACK    = VGA640_V_BACK,
  parameter bit          HSYNC_POL = VGA640_HSYNC_POL,
  parameter bit          VSYNC_POL = VGA640_VSYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [WIDTH-1:0] out_hdata,
  output logic [WIDTH-1:0] out_vdata,
  output logic             out_blank,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_phase
    $error("vga_timing_gen: every phase length must be at least 1");
  end
  if ((longint'(H_TOTAL) - 1) >= (longint'(1) << WIDTH) ||
      (longint'(V_TOTAL) - 1) >= (longint'(1) << WIDTH)) begin : g_bad_width
    $error("vga_timing_gen: WIDTH too small for H_TOTAL/V_TOTAL");
  end

  logic [WIDTH-1:0] w_hcount_nxt;
  logic [WIDTH-1:0] w_vcount_nxt;
  phase_e           w_hphase_nxt;
  phase_e           w_vphase_nxt;
  logic             w_hwrap;
  logic             w_vwrap;
  logic             w_vstep;

  logic r_hsync;
  logic r_vsync;
  logic r_blank;
  logic r_line_start;
  logic r_frame_start;

  assign w_vstep = en & w_hwrap;

  vga_axis_counter #(
    .WIDTH  (WIDTH),
    .VISIBLE(H_VISIBLE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h (
    .clk        (clk),
    .rst        (rst),
    .i_step     (en),
    .o_count    (out_hdata),
    .o_count_nxt(w_hcount_nxt),
    .o_phase_nxt(w_hphase_nxt),
    .o_wrap     (w_hwrap)
  );

  vga_axis_counter #(
    .WIDTH  (WIDTH),
    .VISIBLE(V_VISIBLE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v (
    .clk        (clk),
    .rst        (rst),
    .i_step     (w_vstep),
    .o_count    (out_vdata),
    .o_count_nxt(w_vcount_nxt),
    .o_phase_nxt(w_vphase_nxt),
    .o_wrap     (w_vwrap)
  );

  // Sync, blank and strobes are registered from the counters' next values so
  // they land in the same cycle as the counter registers they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync       <= !HSYNC_POL;
      r_vsync       <= !VSYNC_POL;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= (w_hphase_nxt == PH_SYN) ? HSYNC_POL : !HSYNC_POL;
      r_vsync       <= (w_vphase_nxt == PH_SYN) ? VSYNC_POL : !VSYNC_POL;
      r_blank       <= (w_hcount_nxt >= WIDTH'(H_VISIBLE)) ||
                       (w_vcount_nxt >= WIDTH'(V_VISIBLE));
      r_line_start  <= w_hwrap;
      r_frame_start <= w_hwrap & w_vwrap;
    end
  end

  assign out_hsync   = r_hsync;
  assign out_vsync   = r_vsync;
  assign out_blank   = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic en   = 1'b0;
  logic en_d = 1'b0;

  logic       hs, vs, blank, ls, fs;
  logic [3:0] hd, vd;

  logic        hs_d, vs_d, blank_d, ls_d, fs_d;
  logic [10:0] hd_d, vd_d;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned pos   = 0;  // en-steps since last reset, small instance

  always #5 clk = ~clk;

  vga_timing_gen #(
    .WIDTH(4),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .out_hsync(hs), .out_vsync(vs), .out_hdata(hd), .out_vdata(vd),
    .out_blank(blank), .line_start(ls), .frame_start(fs)
  );

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .en(en_d),
    .out_hsync(hs_d), .out_vsync(vs_d), .out_hdata(hd_d), .out_vdata(vd_d),
    .out_blank(blank_d), .line_start(ls_d), .frame_start(fs_d)
  );

  wire logic [12:0] obs = {hd, vd, blank, hs, vs, ls, fs};

  // Expected packed outputs of the small instance at raster position p.
  function automatic logic [12:0] exp_at(input int unsigned p, input logic e_ls,
                                         input logic e_fs);
    int unsigned h, v;
    logic e_blank, e_hs, e_vs;
    h = p % 8;
    v = (p / 8) % 6;
    e_blank = (h >= 4) || (v >= 3);
    e_hs    = !((h == 5) || (h == 6));
    e_vs    = !(v == 4);
    return {4'(h), 4'(v), e_blank, e_hs, e_vs, e_ls, e_fs};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 13'b0000_0000_0_1_1_0_0) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected %b", obs, 13'b0000_0000_0_1_1_0_0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic test_line_sweep();
    logic [12:0] e;
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      pos++;
      e = exp_at(pos, (pos % 8) == 0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL line_sweep[%0d]: got %b expected %b", k, obs, e);
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [12:0] e;
    int unsigned vs_low;
    vs_low = 0;
    en = 1'b1;
    while (pos < 48) begin
      @(posedge clk); #1;
      pos++;
      e = exp_at(pos, (pos % 8) == 0, (pos % 48) == 0);
      if (vs == 1'b0) vs_low++;
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL frame_wrap[pos %0d]: got %b expected %b", pos, obs, e);
      end
    end
    n_cmp++;
    if ({hd, vd, ls, fs} !== 10'b0000_0000_1_1) begin
      n_bad++;
      $display("FAIL frame_origin: got %b expected %b", {hd, vd, ls, fs}, 10'b0000_0000_1_1);
    end
    n_cmp++;
    if (vs_low !== 8) begin
      n_bad++;
      $display("FAIL vsync_width: got %0d expected 8", vs_low);
    end
  endtask

  task automatic test_en_gating();
    logic [12:0] e;
    logic        stepped;
    int unsigned ls_clks;
    ls_clks = 0;
    for (int c = 0; c < 16; c++) begin
      en = (c % 2) == 0;
      stepped = en;
      @(posedge clk); #1;
      if (stepped) pos++;
      e = exp_at(pos, stepped && ((pos % 8) == 0), stepped && ((pos % 48) == 0));
      if (ls) ls_clks++;
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL en_gating[clk %0d]: got %b expected %b", c, obs, e);
      end
    end
    n_cmp++;
    if (ls_clks !== 1) begin
      n_bad++;
      $display("FAIL line_start_width: got %0d expected 1", ls_clks);
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    en = 1'b1;
    for (int k = 0; k < 48 && (pos % 48) != 38; k++) begin
      @(posedge clk); #1;
      pos++;
    end
    e = exp_at(38, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL pre_reset_pos: got %b expected %b", obs, e);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 13'b0000_0000_0_1_1_0_0) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected %b", obs, 13'b0000_0000_0_1_1_0_0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      pos++;
      e = exp_at(pos, (pos % 8) == 0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL post_reset[%0d]: got %b expected %b", k, obs, e);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_default_params();
    int unsigned h, hs_low_run, last_ls, n_ls;
    logic e_hs, e_ls;
    hs_low_run = 0;
    last_ls    = 0;
    n_ls       = 0;
    en = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    en_d = 1'b1;
    for (int unsigned k = 1; k <= 1700; k++) begin
      @(posedge clk); #1;
      h    = k % 800;
      e_hs = !((h >= 656) && (h < 752));
      e_ls = (h == 0);
      n_cmp++;
      if ({hd_d, hs_d, ls_d, fs_d, blank_d} !== {11'(h), e_hs, e_ls, 1'b0, h >= 640}) begin
        n_bad++;
        $display("FAIL default_h[%0d]: got h=%0d hs=%b ls=%b fs=%b bl=%b expected h=%0d hs=%b ls=%b fs=0 bl=%b",
                 k, hd_d, hs_d, ls_d, fs_d, blank_d, h, e_hs, e_ls, h >= 640);
      end
      if (hs_d == 1'b0) hs_low_run++;
      if (ls_d) begin
        if (n_ls > 0) begin
          n_cmp++;
          if (k - last_ls !== 800) begin
            n_bad++;
            $display("FAIL line_period: got %0d expected 800", k - last_ls);
          end
        end
        last_ls = k;
        n_ls++;
      end
    end
    n_cmp++;
    if (hs_low_run !== 192) begin
      n_bad++;
      $display("FAIL default_hsync_low: got %0d expected 192", hs_low_run);
    end
    n_cmp++;
    if (vd_d !== 11'd2) begin
      n_bad++;
      $display("FAIL default_vdata: got %0d expected 2", vd_d);
    end
    en_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line_sweep();
    test_frame_wrap();
    test_en_gating();
    test_async_reset();
    test_default_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
